// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - state encoding and defaults shared by the UART TX scheduler
package uart_tx_sched_pkg;

    typedef enum logic [2:0] {
        SCH_IDLE  = 3'd0,
        SCH_LOAD  = 3'd1,
        SCH_WAIT  = 3'd2,
        SCH_ERROR = 3'd4
    } sch_state_e;

    localparam int SCH_TIMEOUT_DEF = 8191;
    localparam int SCH_TO_W_DEF    = 13;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// rtl/uart_tx_sched_rr_pick.sv - combinational round-robin picker starting after ptr
module uart_tx_sched_rr_pick
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    gnt,
    output logic             any
);

    logic [PW-1:0] idx;

    // Scan from the farthest candidate back to ptr+1 so the nearest set bit wins.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx = PW'((int'(ptr) + off) % N_REQ);
            if (req[idx]) begin
                gnt = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one UART TX core between byte sources
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TO_W    = SCH_TO_W_DEF,
    parameter int TIMEOUT = SCH_TIMEOUT_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               MOD_RST,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [8*N_REQ-1:0] DATA,
    output logic [N_REQ-1:0]   ACK,
    output logic [7:0]         TX_DATA,
    output logic               TX_START,
    input  logic               TX_DONE,
    output logic               BUSY,
    output logic               ERR
);

    localparam int              PW      = ptr_width(N_REQ);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [PW-1:0]   PTR_RST = PW'(N_REQ - 1);

    sch_state_e       state;
    sch_state_e       nstate;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    gnt;
    logic             any;
    logic [TO_W-1:0]  cnt;
    logic [7:0]       data_b [N_REQ];
    logic [N_REQ-1:0] ack_d;
    logic             start_d;
    logic             busy_d;
    logic             err_d;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign data_b[i] = DATA[8*i +: 8];
    end

    uart_tx_sched_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req (REQ),
        .ptr (ptr),
        .gnt (gnt),
        .any (any)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= SCH_IDLE;
        end else if (MOD_RST) begin
            state <= SCH_IDLE;
        end else begin
            state <= nstate;
        end
    end

    // TX_DONE beats the timeout when both land in the same WAIT cycle.
    always_comb begin
        nstate = SCH_IDLE;
        case (state)
            SCH_IDLE:  nstate = any ? SCH_LOAD : SCH_IDLE;
            SCH_LOAD:  nstate = SCH_WAIT;
            SCH_WAIT: begin
                if (TX_DONE)            nstate = SCH_IDLE;
                else if (cnt == TO_MAX) nstate = SCH_ERROR;
                else                    nstate = SCH_WAIT;
            end
            SCH_ERROR: nstate = SCH_ERROR;
            default:   nstate = SCH_IDLE;
        endcase
    end

    always_comb begin
        ack_d = '0;
        if (state == SCH_LOAD) begin
            ack_d[winner] = 1'b1;
        end
        start_d = (state == SCH_LOAD);
        busy_d  = (nstate == SCH_LOAD) || (nstate == SCH_WAIT);
        err_d   = (nstate == SCH_ERROR);
    end

    // ptr only advances on a completed frame, so an aborted byte is retried in turn.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr      <= PTR_RST;
            winner   <= '0;
            cnt      <= '0;
            TX_DATA  <= '0;
            ACK      <= '0;
            TX_START <= 1'b0;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
        end else if (MOD_RST) begin
            ptr      <= PTR_RST;
            winner   <= '0;
            cnt      <= '0;
            TX_DATA  <= '0;
            ACK      <= '0;
            TX_START <= 1'b0;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            ACK      <= ack_d;
            TX_START <= start_d;
            BUSY     <= busy_d;
            ERR      <= err_d;
            if (state == SCH_IDLE && any) begin
                winner  <= gnt;
                TX_DATA <= data_b[gnt];
            end
            if (state == SCH_LOAD) begin
                cnt <= '0;
            end else if (state == SCH_WAIT && cnt != TO_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (state == SCH_WAIT && TX_DONE) begin
                ptr <= winner;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed and randomized checks of uart_tx_sched against a transaction model
module tb_uart_tx_sched;

    localparam int N       = 4;
    localparam int TIMEOUT = 8191;

    logic           CLK     = 1'b0;
    logic           RST     = 1'b0;
    logic           MOD_RST = 1'b0;
    logic [N-1:0]   req_v   = '0;
    logic [8*N-1:0] data_v  = '0;
    logic           TX_DONE = 1'b0;
    logic [N-1:0]   ACK;
    logic [7:0]     TX_DATA;
    logic           TX_START;
    logic           BUSY;
    logic           ERR;

    int n_chk = 0;
    int n_err = 0;
    int m_ptr = N - 1;

    uart_tx_sched #(
        .N_REQ   (N),
        .TO_W    (13),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .MOD_RST  (MOD_RST),
        .REQ      (req_v),
        .DATA     (data_v),
        .ACK      (ACK),
        .TX_DATA  (TX_DATA),
        .TX_START (TX_START),
        .TX_DONE  (TX_DONE),
        .BUSY     (BUSY),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Next requester in circular order after the last one that completed a frame.
    function automatic int model_pick(input logic [N-1:0] r);
        for (int o = 1; o <= N; o++) begin
            int i;
            i = (m_ptr + o) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        req_v   = '0;
        TX_DONE = 1'b0;
        MOD_RST = 1'b0;
        RST     = 1'b1;
        repeat (2) @(negedge CLK);
        RST   = 1'b0;
        m_ptr = N - 1;
    endtask

    task automatic idle_gap(input int n, input string tag);
        int s;
        s = 0;
        repeat (n) begin
            @(negedge CLK);
            s += int'(TX_START | BUSY);
        end
        check(tag, s, 0);
    endtask

    // One byte: REQ/DATA already driven at this negedge; returns the negedge after TX_DONE.
    task automatic do_byte(input int tx_t, input bit scramble, output int w, output logic [7:0] sent);
        int lat;
        logic [7:0] b;
        lat  = 0;
        sent = 8'h00;
        w    = model_pick(req_v);
        if (w < 0) begin
            check("no_request", 0, 1);
            return;
        end
        b = data_v[8*w +: 8];
        do begin
            @(negedge CLK);
            lat++;
        end while (!TX_START && lat < 40);
        sent = TX_DATA;
        check("start_latency", lat, 2);
        check("tx_data", 32'(TX_DATA), 32'(b));
        check("ack", 32'(ACK), 32'(1) << w);
        check("busy_run", 32'(BUSY), 1);
        @(negedge CLK);
        check("ack_pulse", 32'({TX_START, ACK}), 0);
        if (scramble) data_v[8*w +: 8] = ~b;
        repeat (tx_t - 1) @(negedge CLK);
        check("tx_data_hold", 32'(TX_DATA), 32'(b));
        check("busy_wait", 32'(BUSY), 1);
        TX_DONE = 1'b1;
        @(negedge CLK);
        TX_DONE = 1'b0;
        check("busy_fall", 32'(BUSY), 0);
        check("err_clear", 32'(ERR), 0);
        m_ptr = w;
    endtask

    initial begin
        int         w;
        int         lat;
        int         cyc;
        int         s;
        logic [7:0] sent;
        logic [N-1:0] nb;
        logic [7:0] t2_exp [5];

        t2_exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};

        do_reset();
        check("rst_ack", 32'(ACK), 0);
        check("rst_start", 32'(TX_START), 0);
        check("rst_data", 32'(TX_DATA), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_err", 32'(ERR), 0);

        data_v = 32'h0000_0041;
        req_v  = 4'b0001;
        do_byte(10, 1'b0, w, sent);
        check("t1_byte", 32'(sent), 32'h41);
        req_v = '0;
        idle_gap(6, "t1_single_start");

        do_reset();
        data_v = 32'h4443_4241;
        req_v  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            do_byte($urandom_range(1, 4), 1'b0, w, sent);
            check("t2_order", 32'(sent), 32'(t2_exp[i]));
        end
        req_v = '0;
        idle_gap(3, "t2_idle");

        do_reset();
        data_v = 32'h00CC_00AA;
        req_v  = 4'b0100;
        do_byte(2, 1'b0, w, sent);
        check("t3_first", 32'(sent), 32'hCC);
        req_v = 4'b0101;
        do_byte(2, 1'b0, w, sent);
        check("t3_wrap", 32'(sent), 32'hAA);
        do_byte(2, 1'b0, w, sent);
        check("t3_next", 32'(sent), 32'hCC);
        req_v = '0;
        idle_gap(3, "t3_idle");

        do_reset();
        data_v = 32'h0000_0055;
        req_v  = 4'b0001;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!TX_START && lat < 40);
        check("t4_start", 32'(TX_START), 1);
        req_v = '0;
        cyc = 0;
        while (!ERR && cyc < TIMEOUT + 40) begin
            @(negedge CLK);
            cyc++;
        end
        check("t4_err_cycles", cyc, TIMEOUT + 1);
        check("t4_err_busy", 32'(BUSY), 0);
        req_v = 4'b1111;
        s = 0;
        repeat (12) begin
            @(negedge CLK);
            if (TX_START || BUSY || !ERR) s++;
        end
        check("t4_err_sticky", s, 0);
        MOD_RST = 1'b1;
        req_v   = '0;
        @(negedge CLK);
        MOD_RST = 1'b0;
        m_ptr   = N - 1;
        check("t4_modrst_err", 32'(ERR), 0);
        check("t4_modrst_busy", 32'(BUSY), 0);
        idle_gap(4, "t4_idle");

        do_reset();
        data_v = 32'hD3C2_B100;
        req_v  = 4'b0100;
        do_byte(2, 1'b0, w, sent);
        check("t5_setup", 32'(sent), 32'hC2);
        req_v = 4'b1010;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!TX_START && lat < 40);
        check("t5_first_ack", 32'(ACK), 32'b1000);
        repeat (2) @(negedge CLK);
        MOD_RST = 1'b1;
        @(negedge CLK);
        MOD_RST = 1'b0;
        m_ptr   = N - 1;
        check("t5_busy", 32'(BUSY), 0);
        check("t5_no_ack", 32'(ACK), 0);
        do_byte(3, 1'b0, w, sent);
        check("t5_ptr_reset", 32'(sent), 32'hB1);
        do_byte(3, 1'b0, w, sent);
        check("t5_resend", 32'(sent), 32'hD3);
        req_v = '0;
        idle_gap(3, "t5_idle");

        do_reset();
        data_v = 32'h0000_7766;
        req_v  = 4'b0001;
        do_byte(TIMEOUT, 1'b0, w, sent);
        check("t6_byte", 32'(sent), 32'h66);
        req_v   = '0;
        TX_DONE = 1'b1;
        @(negedge CLK);
        TX_DONE = 1'b0;
        idle_gap(5, "t6_stray");
        check("t6_err", 32'(ERR), 0);
        req_v = 4'b0011;
        do_byte(2, 1'b0, w, sent);
        check("t6_after", 32'(sent), 32'h77);
        req_v = '0;
        idle_gap(2, "t6_idle");

        do_reset();
        for (int t = 0; t < 80; t++) begin
            if (req_v == '0) begin
                idle_gap($urandom_range(1, 4), "rnd_idle");
                req_v  = 4'($urandom_range(1, 15));
                data_v = $urandom;
            end
            do_byte($urandom_range(1, 8), 1'b1, w, sent);
            if ($urandom_range(0, 1) == 1) req_v[w] = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                nb = 4'($urandom) & ~req_v;
                for (int i = 0; i < N; i++) begin
                    if (nb[i]) data_v[8*i +: 8] = 8'($urandom);
                end
                req_v = req_v | nb;
            end
            if ($urandom_range(0, 9) == 0) req_v = '0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
